elevator_scheduler: RTL



---
 rtl/elevator_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// SCAN-policy sequencer for a single elevator car: latches calls, times travel and door dwell.
// Optional door-hold input enabled by defining ELEVATOR_DOOR_HOLD_EN.
module elevator_scheduler #(
  parameter int unsigned FLOORS        = 6,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic              door_hold,
`endif
  input  logic [FLOORS-1:0] call_req,
  output logic [FLOORS-1:0] cur_floor,
  output logic [FLOORS-1:0] pending,
  output logic              door_open,
  output logic              moving_up,
  output logic              moving_down,
  output logic              idle
);

  localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;
  localparam logic [1:0] DOOR      = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [1:0]        state_q, state_d;
  logic [FLOORS-1:0] cur_floor_q, cur_floor_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]     travel_q, travel_d;
  logic [DW-1:0]     door_q, door_d;
  logic              dir_q, dir_d;
  logic [FLOORS-1:0] served;
  logic [FLOORS-1:0] above, below, here;
  logic              hold;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  function automatic logic [FLOORS-1:0] above_of(input logic [FLOORS-1:0] req,
                                                 input logic [FLOORS-1:0] pos);
    logic [FLOORS-1:0] res;
    logic              seen;
    res  = '0;
    seen = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      res[i] = req[i] & seen;
      seen   = seen | pos[i];
    end
    return res;
  endfunction

  function automatic logic [FLOORS-1:0] below_of(input logic [FLOORS-1:0] req,
                                                 input logic [FLOORS-1:0] pos);
    logic [FLOORS-1:0] res;
    logic              seen;
    res  = '0;
    seen = 1'b0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      res[i] = req[i] & seen;
      seen   = seen | pos[i];
    end
    return res;
  endfunction

  assign above = above_of(pending_q, cur_floor_q);
  assign below = below_of(pending_q, cur_floor_q);
  assign here  = pending_q & cur_floor_q;

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    travel_d    = travel_q;
    door_d      = door_q;
    dir_d       = dir_q;
    served      = '0;
    case (state_q)
      IDLE: begin
        if (|here) begin
          state_d = DOOR;
          door_d  = DW'(DOOR_CYCLES);
          served  = cur_floor_q;
        end else if ((dir_q == DIR_UP && |above) || (dir_q == DIR_DOWN && ~|below && |above)) begin
          state_d  = MOVE_UP;
          travel_d = TW'(TRAVEL_CYCLES);
          dir_d    = DIR_UP;
        end else if (|below) begin
          state_d  = MOVE_DOWN;
          travel_d = TW'(TRAVEL_CYCLES);
          dir_d    = DIR_DOWN;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_q == TW'(1)) begin
          cur_floor_d = (state_q == MOVE_UP) ? (cur_floor_q << 1) : (cur_floor_q >> 1);
          // Only requests already latched decide the stop; later calls wait for a later pass.
          if (|(pending_q & cur_floor_d)) begin
            state_d  = DOOR;
            door_d   = DW'(DOOR_CYCLES);
            travel_d = '0;
            served   = cur_floor_d;
          end else if ((state_q == MOVE_UP   && |above_of(pending_q, cur_floor_d)) ||
                       (state_q == MOVE_DOWN && |below_of(pending_q, cur_floor_d))) begin
            travel_d = TW'(TRAVEL_CYCLES);
          end else begin
            state_d  = IDLE;
            travel_d = '0;
          end
        end else begin
          travel_d = travel_q - TW'(1);
        end
      end
      DOOR: begin
        served = cur_floor_q;
        if (hold || |(call_req & cur_floor_q)) begin
          door_d = DW'(DOOR_CYCLES);
        end else if (door_q == DW'(1)) begin
          state_d = IDLE;
          door_d  = '0;
        end else begin
          door_d = door_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | call_req) & ~served;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_floor_q <= FLOORS'(1);
      pending_q   <= '0;
      travel_q    <= '0;
      door_q      <= '0;
      dir_q       <= DIR_UP;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      pending_q   <= pending_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
      dir_q       <= dir_d;
    end
  end

  assign cur_floor   = cur_floor_q;
  assign pending     = pending_q;
  assign door_open   = (state_q == DOOR);
  assign moving_up   = (state_q == MOVE_UP);
  assign moving_down = (state_q == MOVE_DOWN);
  assign idle        = (state_q == IDLE) && (pending_q == '0);

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(cur_floor_q));
  a_top:    assert property (@(posedge clk) disable iff (reset)
                             (state_q == MOVE_UP) |-> !cur_floor_q[FLOORS-1]);
  a_bottom: assert property (@(posedge clk) disable iff (reset)
                             (state_q == MOVE_DOWN) |-> !cur_floor_q[0]);
`endif

endmodule
